// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// hex decode table and legal parameter bounds.
package seven_seg_pkg;

   localparam int unsigned SEG_W            = 7;
   localparam int unsigned HEX_W            = 4;
   localparam int unsigned BRIGHT_W         = 4;
   localparam int unsigned PWM_LEVELS       = 16;

   localparam int unsigned MIN_DIGITS       = 1;
   localparam int unsigned MAX_DIGITS       = 8;
   localparam int unsigned MIN_DEAD_CYCLES  = 1;
   localparam int unsigned MIN_ACTIVE_SPAN  = PWM_LEVELS;

   localparam logic [SEG_W-1:0]    SEG_BLANK   = 7'h7F;
   localparam logic [BRIGHT_W-1:0] BRIGHT_OFF  = 4'h0;
   localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = 4'hF;

   // Active-low {a,b,c,d,e,f,g} pattern for one hex nibble.
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [HEX_W-1:0] hex);
      logic [SEG_W-1:0] seg;
      seg = SEG_BLANK;
      case (hex)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0001100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         4'hF: seg = 7'b0111000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seven_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [HEX_W-1:0] i_hex,
   output logic [SEG_W-1:0] o_seg_c
);

   assign o_seg_c = hex_to_seg(i_hex);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment scanner: per-frame snapshot, dead-time
// blanking between digits, 16-level PWM brightness and per-digit enables.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 2,
   parameter int unsigned SLOT_CYCLES    = 24000,
   parameter int unsigned DEAD_CYCLES    = 240,
   parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [SEG_W-1:0]        seg,
   output logic [NUM_DIGITS-1:0]   select,
   output logic                    frame_start
);

   localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0]      DEAD_END = CNT_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{SEL_ACTIVE_LOW}};

   logic [CNT_W-1:0]        r_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_snap_digits;
   logic [NUM_DIGITS-1:0]   r_snap_en;
   logic [SEG_W-1:0]        r_seg;
   logic [NUM_DIGITS-1:0]   r_select;
   logic                    r_frame_start;

   logic [CNT_W-1:0]        w_cnt_nxt;
   logic [IDX_W-1:0]        w_idx_nxt;
   logic                    w_slot_end;
   logic                    w_frame_load;
   logic [HEX_W-1:0]        w_cur_hex;
   logic                    w_cur_en;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic                    w_pwm_on;
   logic                    w_dead;
   logic                    w_lit;
   logic [SEG_W-1:0]        w_dec_seg;

   // Slot counter and digit index sequencing.
   always_comb begin
      w_slot_end   = (r_cnt == CNT_LAST);
      w_cnt_nxt    = w_slot_end ? '0 : r_cnt + CNT_W'(1);
      w_idx_nxt    = r_idx;
      w_frame_load = (r_cnt == '0) && (r_idx == '0);
      if (w_slot_end) begin
         w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
   end

   // Pick the current digit's nibble, enable and select bit from the snapshot.
   always_comb begin
      w_cur_hex = '0;
      w_cur_en  = 1'b0;
      w_onehot  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_cur_hex   = r_snap_digits[4*i +: 4];
            w_cur_en    = r_snap_en[i];
            w_onehot[i] = 1'b1;
         end
      end
   end

   // Brightness is live; full and off are forced so level 15 never drops a cycle.
   always_comb begin
      w_pwm_on = 1'b0;
      if (brightness == BRIGHT_FULL) begin
         w_pwm_on = 1'b1;
      end else if (brightness != BRIGHT_OFF) begin
         w_pwm_on = (r_cnt[3:0] < brightness);
      end
      w_dead = (r_cnt < DEAD_END);
      w_lit  = !w_dead && w_cur_en && w_pwm_on;
   end

   seven_seg_decode u_decode (
      .i_hex   (w_cur_hex),
      .o_seg_c (w_dec_seg)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt         <= '0;
         r_idx         <= '0;
         r_snap_digits <= '0;
         r_snap_en     <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_idx <= w_idx_nxt;
         if (w_frame_load) begin
            r_snap_digits <= digits;
            r_snap_en     <= digit_en;
         end
      end
   end

   // Pin registers reflect the pre-edge (cnt, idx) state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_seg         <= SEG_BLANK;
         r_select      <= SEL_IDLE;
         r_frame_start <= 1'b0;
      end else begin
         r_seg         <= w_lit ? w_dec_seg : SEG_BLANK;
         r_select      <= w_lit ? (w_onehot ^ SEL_IDLE) : SEL_IDLE;
         r_frame_start <= w_frame_load;
      end
   end

   assign seg         = r_seg;
   assign select      = r_select;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed phases plus random input churn, checked
// every cycle against a frame/slot arithmetic model of the display.
module tb_seven_seg_scan;

   localparam int ND    = 4;
   localparam int SC    = 32;
   localparam int DC    = 2;
   localparam int FRAME = ND * SC;

   localparam logic [6:0] DEC [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] digits = '0;
   logic [3:0]  digit_en = '0;
   logic [3:0]  brightness = '0;
   logic [6:0]  seg, seg_b;
   logic [3:0]  sel, sel_b;
   logic        fs, fs_b;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: p = cycles of scanning since reset release.
   int          p = 0;
   logic [15:0] m_dig = '0;
   logic [3:0]  m_en = '0;
   logic [6:0]  e_seg = 7'h7F;
   logic [3:0]  e_sel = '0;
   logic        e_fs = 1'b0;

   always #5 clk = ~clk;

   seven_seg_scan #(.NUM_DIGITS(ND), .SLOT_CYCLES(SC), .DEAD_CYCLES(DC), .SEL_ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en), .brightness(brightness),
      .seg(seg), .select(sel), .frame_start(fs)
   );

   seven_seg_scan #(.NUM_DIGITS(ND), .SLOT_CYCLES(SC), .DEAD_CYCLES(DC), .SEL_ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en), .brightness(brightness),
      .seg(seg_b), .select(sel_b), .frame_start(fs_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h p=%0d", tag, obs, exp, p);
      end
   endtask

   function automatic bit pwm_on(input int b, input int c);
      if (b == 15) return 1'b1;
      if (b == 0)  return 1'b0;
      return (c % 16) < b;
   endfunction

   task automatic check_outputs();
      logic [3:0] inv;
      inv = ~e_sel;
      check("seg", 32'(seg), 32'(e_seg));
      check("select", 32'(sel), 32'(e_sel));
      check("frame_start", 32'(fs), 32'(e_fs));
      check("seg_al", 32'(seg_b), 32'(e_seg));
      check("select_al", 32'(sel_b), 32'(inv));
      check("frame_start_al", 32'(fs_b), 32'(e_fs));
   endtask

   // Predict the pins for the next edge from the scan position, then clock and compare.
   task automatic tick();
      int c, d, h;
      c = p % SC;
      d = (p / SC) % ND;
      if (p % FRAME == 0) begin
         m_dig = digits;
         m_en  = digit_en;
      end
      e_fs = (p % FRAME == 0);
      if (c >= DC && m_en[d] && pwm_on(int'(brightness), c)) begin
         h     = int'(m_dig >> (4 * d)) & 15;
         e_seg = DEC[h];
         e_sel = 4'(1 << d);
      end else begin
         e_seg = 7'h7F;
         e_sel = 4'h0;
      end
      @(posedge clk);
      p++;
      #1;
      check_outputs();
   endtask

   task automatic reset_cycle();
      @(posedge clk);
      #1;
      e_seg = 7'h7F;
      e_sel = 4'h0;
      e_fs  = 1'b0;
      check_outputs();
   endtask

   task automatic run_to(input int pos);
      for (int k = 0; k < FRAME && (p % FRAME) != pos; k++) tick();
   endtask

   initial begin
      int lit_cnt [ND];
      int fs_cnt;
      int first_lit;

      // Reset held low: idle pins.
      for (int k = 0; k < 5; k++) reset_cycle();

      // Basic scan of 3A05 at full brightness, two frames.
      digits     = 16'h3A05;
      digit_en   = 4'hF;
      brightness = 4'd15;
      reset      = 1'b1;
      p          = 0;
      for (int k = 0; k < 2 * FRAME; k++) tick();

      // Snapshot: change digits mid slot 1, visible only after next frame load.
      run_to(SC + 5);
      digits = 16'hFFFF;
      for (int k = 0; k < 2 * FRAME; k++) tick();

      // PWM level 4 with digits 1 and 3 disabled.
      brightness = 4'd4;
      digit_en   = 4'b0101;
      run_to(0);
      for (int d = 0; d < ND; d++) lit_cnt[d] = 0;
      fs_cnt = 0;
      for (int k = 0; k < FRAME; k++) begin
         tick();
         for (int d = 0; d < ND; d++) if (sel == 4'(1 << d)) lit_cnt[d]++;
         if (fs) fs_cnt++;
      end
      check("pwm_lit_d0", 32'(lit_cnt[0]), 32'd6);
      check("pwm_lit_d1", 32'(lit_cnt[1]), 32'd0);
      check("pwm_lit_d2", 32'(lit_cnt[2]), 32'd6);
      check("pwm_lit_d3", 32'(lit_cnt[3]), 32'd0);
      check("frame_start_per_frame", 32'(fs_cnt), 32'd1);

      // Async reset at cnt 10 of slot 2 while digit 2 is lit.
      digits     = 16'h3A05;
      digit_en   = 4'hF;
      brightness = 4'd15;
      run_to(0);
      run_to(2 * SC + 10);
      check("pre_reset_lit", 32'(sel), 32'h4);
      reset = 1'b0;
      #1;
      e_seg = 7'h7F;
      e_sel = 4'h0;
      e_fs  = 1'b0;
      check_outputs();
      for (int k = 0; k < 3; k++) reset_cycle();
      reset = 1'b1;
      p     = 0;
      first_lit = -1;
      for (int k = 1; k <= 2 * SC && first_lit < 0; k++) begin
         tick();
         if (sel != 4'h0) begin
            first_lit = k;
            check("first_lit_digit", 32'(sel), 32'h1);
         end
      end
      check("first_lit_latency", 32'(first_lit), 32'(DC + 1));

      // Random churn of all inputs over several frames.
      for (int k = 0; k < 8 * FRAME; k++) begin
         if ($urandom_range(0, 15) == 0) digits = 16'($urandom);
         if ($urandom_range(0, 31) == 0) digit_en = 4'($urandom);
         if ($urandom_range(0, 7) == 0) brightness = 4'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised time-multiplexed seven-segment display driver for up to eight common-segment digits. It captures a frame of hex digit values, scans them one digit per slot and inserts a dead-time blank between digits to suppress ghosting. It also provides 16-level PWM brightness and per-digit blanking. It sits between the board-level input logic and the display pins, clocked from the on-chip high-speed oscillator.

## Interface
Parameters:
- NUM_DIGITS, 2, number of digits scanned, legal range 1..8
- SLOT_CYCLES, 24000, clock cycles per digit slot, must be ≥ DEAD_CYCLES + 16
- DEAD_CYCLES, 240, blank cycles at the start of each slot, must be ≥ 1
- SEL_ACTIVE_LOW, 0, 1 inverts every bit of select

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting clears all state immediately
- digits  in  4*NUM_DIGITS  hex values; digit i = digits[4i+3:4i], digit 0 rightmost
- digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit
- brightness  in  4  PWM level; 0 = off, 15 = always on
- seg  out  7  active-low segments {a,b,c,d,e,f,g} on seg[6:0]; blank = 7'h7F
- select  out  NUM_DIGITS  one-hot digit drive, active-high unless SEL_ACTIVE_LOW
- frame_start  out  1  one-cycle pulse when a new frame snapshot is loaded

## Operation
- Internal state: slot counter cnt (0..SLOT_CYCLES-1), digit index idx (0..NUM_DIGITS-1), snapshot registers snap_digits and snap_en.
- cnt increments every cycle. On SLOT_CYCLES-1 it wraps to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Snapshot: digits and digit_en load into snap_* on the edge where (idx==0, cnt==0). Input changes at any other time have no effect until the next frame.
- Dead time: while cnt < DEAD_CYCLES, seg = 7'h7F and no select bit is active.
- Active phase: when cnt ≥ DEAD_CYCLES, the digit is lit only if snap_en[idx]==1 and pwm_on==1.
  - pwm_on is 1 when brightness==15.
  - pwm_on is 0 when brightness==0.
  - Otherwise pwm_on = (cnt[3:0] < brightness).
- When lit: seg = decode(snap_digits[idx]) and select = one-hot(idx). When not lit: seg = 7'h7F and select is all inactive.
- Decode table, 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Reset values:
  - cnt = 0, idx = 0, snapshot = 0
  - seg = 7'h7F
  - select = all inactive (0, or all-ones when SEL_ACTIVE_LOW)
  - frame_start = 0

## Timing
- seg, select and frame_start are registered. Each reflects the (cnt, idx) state before the same clock edge, giving one cycle of latency from state to pins.
- frame_start is high for exactly one cycle per frame, in the cycle after the snapshot load. Frame period = NUM_DIGITS*SLOT_CYCLES.
- First edge after reset release: the snapshot loads and frame_start asserts on the next cycle. Digit 0 is lit no earlier than DEAD_CYCLES+1 cycles after release.
- DEAD_CYCLES ≥ 1 guarantees the snapshot is stable before any digit is lit, and that select never changes between two active digits without a blank cycle.
- Reset asserted mid-slot: outputs go to reset values asynchronously. After release, scanning restarts at digit 0, cnt 0.
- brightness is sampled live, not snapshotted, so a change takes effect within one cycle.

## Structure
- Package seven_seg_pkg: segment pattern constants (SEG_BLANK = 7'h7F, 16-entry decode table as a function or constant array) and the legal parameter bounds.
- Sub-module seven_seg_decode: combinational 4-bit hex to active-low 7-bit segment decoder, one instance.
- Counter widths: cnt = $clog2(SLOT_CYCLES), idx = max(1, $clog2(NUM_DIGITS)).

## Test plan
Bench parameters: NUM_DIGITS=4, SLOT_CYCLES=32, DEAD_CYCLES=2.
- Reset: hold reset=0 for 5 cycles -> seg=7'h7F, select=4'b0000, frame_start=0. Release -> frame_start pulses once, then every 128 cycles.
- Basic scan: digits=16'h3A05, digit_en=4'hF, brightness=15 -> per slot, 2 blank cycles, then 30 cycles showing:
  - select=0001, seg=0100100
  - select=0010, seg=0000001
  - select=0100, seg=0001000
  - select=1000, seg=0000110
- Snapshot: change digits to 16'hFFFF mid-slot 1 -> display unchanged until after the next frame_start, then all digits show seg=0111000.
- PWM and enable: brightness=4, digit_en=4'b0101 -> digits 0 and 2 are lit for exactly 6 cycles per slot (cnt 2,3,16..19). Digits 1 and 3 stay fully blank.
- Async reset mid-slot: drop reset at cnt=10 of slot 2 -> outputs blank in the same cycle. After release, the first lit digit is digit 0.
- Polarity: SEL_ACTIVE_LOW=1 with the basic scan -> idle select=4'b1111, lit digit 0 select=4'b1110, seg unchanged.
